// File: rtl/vend_controller.sv
// Multi-product vending sequencer: accumulates coin credit, validates selections
// against price and stock, handshakes a dispense and pays out change pulses.
module vend_controller #(
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 3,
    parameter int STOCK_INIT = 2,
    parameter int PRICE0     = 2,
    parameter int PRICE1     = 3,
    parameter int PRICE2     = 4,
    parameter int PRICE3     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                restock,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    output logic                change,
    output logic                coin_reject,
    output logic                sel_err,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          sold_out,
    output logic [1:0]          c_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DISPENSE = 2'b01,
        S_CHANGE   = 2'b10
    } state_t;

    state_t              state;
    logic [STOCK_W-1:0]  stock [4];

    logic                coin_present;
    logic                coin_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    // Coin code 01 adds one step and 10 adds two, so the code itself is the increment.
    always_comb begin
        coin_present = (in != 2'b00);
        coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(in);
        coin_ok      = (in != 2'b11) && coin_present && !coin_sum[CREDIT_W];
        sel_price    = price_of(sel_id);
        sel_ok       = (stock[sel_id] != '0) && (credit >= sel_price);
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < 4; i++) sold_out[i] = (stock[i] == '0);
    end

    assign c_state = state;

    // NOTE: every register below is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_id     <= 2'd0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            change      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cancel) begin
                        coin_reject <= coin_present;
                        if (credit != '0) begin
                            state  <= S_CHANGE;
                            change <= 1'b1;
                            credit <= credit - 1'b1;
                        end
                    end else if (sel_valid) begin
                        coin_reject <= coin_present;
                        if (sel_ok) begin
                            state          <= S_DISPENSE;
                            credit         <= credit - sel_price;
                            stock[sel_id]  <= stock[sel_id] - 1'b1;
                            disp_req       <= 1'b1;
                            disp_id        <= sel_id;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end else if (restock) begin
                        coin_reject <= coin_present;
                        for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT);
                    end else if (coin_present) begin
                        if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
                        else         coin_reject <= 1'b1;
                    end
                end
                S_DISPENSE: begin
                    coin_reject <= coin_present;
                    sel_err     <= sel_valid;
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        if (credit != '0) begin
                            state  <= S_CHANGE;
                            change <= 1'b1;
                            credit <= credit - 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_CHANGE: begin
                    // The pulse paid on entry accounts for one step; keep paying until credit is empty.
                    coin_reject <= coin_present;
                    sel_err     <= sel_valid;
                    if (credit != '0) begin
                        change <= 1'b1;
                        credit <= credit - 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model queues expected
// output events; a monitor pops and compares whenever the DUT shows one.
module tb_vend_controller;

    localparam int MAX_CREDIT = 15;
    localparam int STOCK_INIT = 2;
    localparam int K_REJ = 0, K_SELERR = 1, K_DISP = 2, K_CHG = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       change;
    logic       coin_reject;
    logic       sel_err;
    logic [3:0] credit;
    logic [3:0] sold_out;
    logic [1:0] c_state;

    int compared   = 0;
    int mismatched = 0;

    ev_t q[$];
    int  m_credit;
    int  m_stock[4];
    int  price[4] = '{2, 3, 4, 6};
    bit  pend_disp;
    int  pend_id;

    vend_controller dut (
        .clk(clk), .rst(rst), .in(in), .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .restock(restock), .disp_ack(disp_ack),
        .disp_req(disp_req), .disp_id(disp_id), .change(change),
        .coin_reject(coin_reject), .sel_err(sel_err), .credit(credit),
        .sold_out(sold_out), .c_state(c_state)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_REJ:    return "coin_reject";
            K_SELERR: return "sel_err";
            K_DISP:   return "dispense";
            default:  return "change_burst";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        compared++;
        if (q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_%s: got value %0d expected no event at %0t", kname(kind), val, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val) begin
                mismatched++;
                $display("FAIL event: got %s=%0d expected %s=%0d at %0t",
                         kname(kind), val, kname(e.kind), e.val, $time);
            end
        end
    endtask

    // Monitor: one event per pulse, per dispense start, per whole change burst.
    initial begin
        int  run = 0;
        bit  prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
                prev_req = 1'b0;
            end else begin
                if (coin_reject) expect_ev(K_REJ, 0);
                if (sel_err) expect_ev(K_SELERR, 0);
                if (disp_req && !prev_req) expect_ev(K_DISP, int'(disp_id));
                prev_req = disp_req;
                if (change) run++;
                else if (run > 0) begin
                    expect_ev(K_CHG, run);
                    run = 0;
                end
            end
        end
    end

    function automatic int exp_sold_out();
        int v = 0;
        for (int i = 0; i < 4; i++) if (m_stock[i] == 0) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
        pend_disp = 1'b0;
        q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(c_state == 2'b00 && !change && !disp_req) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached_in_budget", int'(n < 40), 1);
    endtask

    task automatic check_state();
        check("credit", int'(credit), m_credit);
        check("sold_out", int'(sold_out), exp_sold_out());
        check("c_state_idle", int'(c_state), 0);
    endtask

    task automatic finish_dispense(input int hold_req);
        int hold = (hold_req < 0) ? int'($urandom_range(0, 3)) : hold_req;
        for (int h = 0; h < hold; h++) begin
            int  coin = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            bit  sel  = ($urandom_range(0, 3) == 0);
            check("disp_req_held", int'(disp_req), 1);
            check("disp_id_held", int'(disp_id), pend_id);
            in = 2'(coin);
            sel_valid = sel;
            sel_id = 2'($urandom_range(0, 3));
            cancel = ($urandom_range(0, 3) == 0);
            restock = ($urandom_range(0, 3) == 0);
            if (coin != 0) push(K_REJ, 0);
            if (sel) push(K_SELERR, 0);
            @(negedge clk);
            in = 2'b00; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
        end
        check("disp_req_before_ack", int'(disp_req), 1);
        disp_ack = 1'b1;
        if (m_credit > 0) push(K_CHG, m_credit);
        m_credit = 0;
        pend_disp = 1'b0;
        @(negedge clk);
        disp_ack = 1'b0;
    endtask

    // Drives one IDLE-state cycle and updates the model from the priority rules.
    task automatic issue(input int coin, input bit sel, input int id, input bit can, input bit rs);
        bit other = can || sel || rs;
        @(negedge clk);
        in = 2'(coin); sel_valid = sel; sel_id = 2'(id); cancel = can; restock = rs;
        if (coin != 0 && (other || coin == 3 || m_credit + coin > MAX_CREDIT)) push(K_REJ, 0);
        if (can) begin
            if (m_credit > 0) push(K_CHG, m_credit);
            m_credit = 0;
        end else if (sel) begin
            if (m_stock[id] == 0 || m_credit < price[id]) push(K_SELERR, 0);
            else begin
                m_credit -= price[id];
                m_stock[id]--;
                push(K_DISP, id);
                pend_disp = 1'b1;
                pend_id = id;
            end
        end else if (rs) begin
            for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
        end else if (coin == 1 || coin == 2) begin
            if (m_credit + coin <= MAX_CREDIT) m_credit += coin;
        end
        @(negedge clk);
        in = 2'b00; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
    endtask

    task automatic op(input int coin, input bit sel, input int id, input bit can, input bit rs,
                      input int hold);
        issue(coin, sel, id, can, rs);
        if (pend_disp) finish_dispense(hold);
        wait_idle();
        check_state();
    endtask

    task automatic coin_op(input int c);
        op(c, 1'b0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic sel_op(input int id, input int hold);
        op(0, 1'b1, id, 1'b0, 1'b0, hold);
    endtask

    task automatic cancel_op();
        op(0, 1'b0, 0, 1'b1, 1'b0, -1);
    endtask

    task automatic restock_op();
        op(0, 1'b0, 0, 1'b0, 1'b1, -1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_credit", int'(credit), 0);
        check("reset_sold_out", int'(sold_out), 0);
        check("reset_c_state", int'(c_state), 0);
        check("reset_disp_req", int'(disp_req), 0);
        check("reset_change", int'(change), 0);
        rst = 1'b1;

        coin_op(2); coin_op(2);
        check("credit_after_two_10s", int'(credit), 4);
        sel_op(1, 3);

        coin_op(1); coin_op(1);
        sel_op(0, 1);

        coin_op(1);
        sel_op(1, -1);
        check("credit_kept_after_sel_err", int'(credit), 1);
        cancel_op();

        restock_op();
        coin_op(2); sel_op(0, 0);
        coin_op(2); sel_op(0, 2);
        check("sold_out0_after_two_buys", int'(sold_out[0]), 1);
        coin_op(2); sel_op(0, -1);
        check("credit_kept_when_sold_out", int'(credit), 2);
        restock_op();
        check("sold_out0_after_restock", int'(sold_out[0]), 0);
        cancel_op();

        coin_op(3);
        repeat (7) coin_op(2);
        check("credit_after_seven_10s", int'(credit), 14);
        coin_op(2);
        check("credit_after_overflow_reject", int'(credit), 14);
        coin_op(1);
        check("credit_at_max", int'(credit), 15);
        coin_op(3);
        cancel_op();

        op(1, 1'b1, 3, 1'b0, 1'b0, -1);
        op(2, 1'b0, 0, 1'b1, 1'b0, -1);
        op(1, 1'b0, 0, 1'b0, 1'b1, -1);
        cancel_op();

        // Asynchronous reset in the middle of a dispense with credit left over.
        coin_op(2); coin_op(2); coin_op(2); coin_op(1);
        issue(0, 1'b1, 2, 1'b0, 1'b0);
        check("disp_req_before_reset", int'(disp_req), 1);
        check("credit_before_reset", int'(credit), 3);
        #2 rst = 1'b0;
        #1;
        check("async_disp_req", int'(disp_req), 0);
        check("async_credit", int'(credit), 0);
        check("async_c_state", int'(c_state), 0);
        check("async_sold_out", int'(sold_out), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check_state();

        for (int n = 0; n < 200; n++) begin
            int r = int'($urandom_range(0, 9));
            int side = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            case (r)
                0, 1, 2, 3, 4: coin_op(int'($urandom_range(1, 3)));
                5, 6:          op(side, 1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0, -1);
                7:             op(side, 1'b0, 0, 1'b1, 1'b0, -1);
                8:             op(side, 1'b0, 0, 1'b0, 1'b1, -1);
                default: begin
                    @(negedge clk);
                    disp_ack = 1'b1;
                    @(negedge clk);
                    disp_ack = 1'b0;
                    wait_idle();
                    check_state();
                end
            endcase
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Multi-product vending controller that sequences the coin-accept datapath, product dispense mechanism and change return. It accumulates credit in 5-unit steps and validates selections against per-product price and stock. It issues a dispense handshake to the mechanism, then pays out remaining credit as 5-unit change pulses. It is the top-level sequencer above the single-product coin FSM.

Parameters:
CREDIT_W, 4, credit register width in 5-unit steps (max credit 2^CREDIT_W-1)
STOCK_W, 3, per-product stock counter width
STOCK_INIT, 2, stock loaded per product on reset/restock
PRICE0, 2, product 0 price in 5-unit steps (10)
PRICE1, 3, product 1 price (15)
PRICE2, 4, product 2 price (20)
PRICE3, 6, product 3 price (30)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in  in  2  coin: 00 none, 01 = 5, 10 = 10, 11 invalid
sel_valid  in  1  selection strobe, one cycle
sel_id  in  2  selected product 0..3
cancel  in  1  refund request
restock  in  1  reload all stock counters
disp_ack  in  1  mechanism has dispensed
disp_req  out  1  dispense request, held until ack
disp_id  out  2  product being dispensed
change  out  1  one 5-unit coin returned per high cycle
coin_reject  out  1  one-cycle pulse: coin not accepted
sel_err  out  1  one-cycle pulse: selection refused
credit  out  CREDIT_W  current credit
sold_out  out  4  bit i = stock[i]==0
c_state  out  2  IDLE=00, DISPENSE=01, CHANGE=10

Behaviour:
- Reset (rst low, async): c_state=IDLE; credit=0; every stock=STOCK_INIT; all pulse outputs, disp_req, disp_id, change = 0. Takes effect immediately, including mid-dispense or mid-change; credit is discarded.
- All outputs are registered except sold_out, which is decoded from the stock registers.
- IDLE, per-cycle priority: cancel > sel_valid > restock > coin.
  - cancel with credit>0: go to CHANGE. With credit==0: no effect.
  - sel_valid: refused with sel_err=1 next cycle, state and credit unchanged, if stock[sel_id]==0 or credit<PRICE[sel_id]. Otherwise next cycle: credit-=price, stock[sel_id]-=1, disp_req=1, disp_id=sel_id, c_state=DISPENSE.
  - restock: all stocks=STOCK_INIT.
  - coin 01/10: credit += 1/2 if the result is <= 2^CREDIT_W-1. Otherwise credit is unchanged and coin_reject=1 next cycle.
  - coin 11 is always rejected.
  - A coin arriving in the same cycle as cancel, sel_valid or restock is rejected.
- DISPENSE:
  - disp_req and disp_id are held stable until disp_ack is sampled high.
  - On the next cycle disp_req=0, and the state goes to CHANGE if credit>0, else IDLE.
  - Coins are rejected (coin_reject pulse). sel_valid gives sel_err. cancel and restock are ignored.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - Each cycle: change=1 and credit-=1.
  - The cycle in which credit reaches 0 is the last change pulse; the state returns to IDLE next.
  - Credit N produces exactly N consecutive change pulses.
  - Coins are rejected, sel_valid gives sel_err, cancel and restock are ignored.
- Credit arithmetic: unsigned, never wraps; subtraction happens only after a passed credit>=price check.
- Stock never underflows; a decrement occurs only on an accepted selection.
- Only one transaction can be in flight at a time.

Test Plan:
- Reset, in=10 then 10 (credit=4), sel_id=1 -> disp_req=1/disp_id=1, credit=1. disp_ack after 3 cycles -> disp_req drops, one change pulse, IDLE, credit=0, stock[1]=1.
- in=5,5 (credit=2), sel_id=0 -> dispense, ack -> straight back to IDLE, no change pulse, credit=0.
- credit=1, sel_id=1 -> sel_err pulse, credit stays 1, IDLE. Then cancel -> exactly one change pulse, credit=0.
- Buy product 0 twice (STOCK_INIT=2) -> sold_out[0]=1. Third select with credit=2 -> sel_err, credit kept. restock -> sold_out[0]=0.
- Seven 10-coins -> credit=14. Another 10 -> coin_reject, credit=14. Then a 5 -> credit=15. in=11 -> coin_reject at any credit.
- rst low while disp_req=1 and credit=3 -> disp_req=0, credit=0, c_state=IDLE, all stock=STOCK_INIT immediately, without waiting for a clock edge.
